// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared encodings, FSM states and oversample constants for uart_cfg
package uart_cfg_pkg;

  localparam int OS_TICKS = 16;
  localparam logic [4:0] START_SAMPLE = 5'd7;
  localparam logic [4:0] BIT_SAMPLE   = 5'd15;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [1:0] STOP_1   = 2'd0;
  localparam logic [1:0] STOP_1P5 = 2'd1;
  localparam logic [1:0] STOP_2   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_t;

  function automatic logic par_en(input logic [1:0] sel);
    return (sel == PAR_EVEN) || (sel == PAR_ODD);
  endfunction

  // ones_odd is the XOR reduction of the data bits
  function automatic logic par_bit(input logic [1:0] sel, input logic ones_odd);
    return (sel == PAR_ODD) ? ~ones_odd : ones_odd;
  endfunction

  function automatic logic [4:0] stop_last(input logic [1:0] sel);
    case (sel)
      STOP_1:   return 5'd15;
      STOP_1P5: return 5'd23;
      default:  return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/uart_cfg_fifo.sv
// rtl/uart_cfg_fifo.sv - sync_fifo_sr: show-ahead FIFO with synchronous active-low reset
module sync_fifo_sr #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] w_data,
  output logic [W-1:0] r_data,
  output logic         empty,
  output logic         full
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  // a write into a full FIFO is still accepted when a read frees a slot
  assign wr_en  = wr & (~full | rd);
  assign rd_en  = rd & ~empty;
  assign empty  = (count == '0);
  assign full   = (count == DEPTH);
  assign r_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= w_data;
  end

endmodule

// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - runtime-configurable 16x oversampled UART with RX/TX FIFOs
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int DVSR_BIT = 11,
  parameter int FIFO_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic [1:0]          par_sel,
  input  logic [1:0]          stop_sel,
  input  logic                rx,
  input  logic                rd_uart,
  input  logic                wr_uart,
  input  logic [DBIT-1:0]     w_data,
  input  logic                clr_ovr,
  output logic [DBIT-1:0]     r_data,
  output logic                r_perr,
  output logic                r_ferr,
  output logic                rx_empty,
  output logic                tx_full,
  output logic                tx_idle,
  output logic                overrun,
  output logic                tx
);

  localparam int NW = $clog2(DBIT);

  logic [DVSR_BIT-1:0] b_cnt;
  logic                tick;

  assign tick = (b_cnt >= dvsr);

  always_ff @(posedge clk) begin
    if (!reset) b_cnt <= '0;
    else        b_cnt <= tick ? '0 : b_cnt + 1'b1;
  end

  logic rx_q1, rx_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  uart_state_t     rx_state, rx_state_n;
  logic [4:0]      rx_cnt, rx_cnt_n;
  logic [NW-1:0]   rx_n, rx_n_n;
  logic [DBIT-1:0] rx_b, rx_b_n;
  logic [1:0]      rx_par, rx_par_n, rx_stop, rx_stop_n;
  logic            rx_perr, rx_perr_n, rx_ferr, rx_ferr_n;
  logic            rx_push;
  logic [DBIT+1:0] rx_wdata, rx_head;
  logic            rx_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
      rx_par   <= PAR_NONE;
      rx_stop  <= STOP_1;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_n     <= rx_n_n;
      rx_b     <= rx_b_n;
      rx_par   <= rx_par_n;
      rx_stop  <= rx_stop_n;
      rx_perr  <= rx_perr_n;
      rx_ferr  <= rx_ferr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_n_n     = rx_n;
    rx_b_n     = rx_b;
    rx_par_n   = rx_par;
    rx_stop_n  = rx_stop;
    rx_perr_n  = rx_perr;
    rx_ferr_n  = rx_ferr;
    rx_push    = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (!rx_s) begin
          rx_state_n = ST_START;
          rx_cnt_n   = '0;
          rx_par_n   = par_sel;
          rx_stop_n  = stop_sel;
          rx_perr_n  = 1'b0;
          rx_ferr_n  = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rx_cnt == START_SAMPLE) begin
            rx_cnt_n   = '0;
            rx_n_n     = '0;
            rx_state_n = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_n = rx_cnt + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (rx_cnt == BIT_SAMPLE) begin
            rx_cnt_n = '0;
            rx_b_n   = {rx_s, rx_b[DBIT-1:1]};
            if (rx_n == NW'(DBIT-1)) rx_state_n = par_en(rx_par) ? ST_PAR : ST_STOP;
            else                     rx_n_n     = rx_n + 1'b1;
          end else begin
            rx_cnt_n = rx_cnt + 5'd1;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          if (rx_cnt == BIT_SAMPLE) begin
            rx_cnt_n   = '0;
            rx_perr_n  = (rx_s != par_bit(rx_par, ^rx_b));
            rx_state_n = ST_STOP;
          end else begin
            rx_cnt_n = rx_cnt + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          // only the first stop bit is checked; a 1-stop frame samples and completes on the same tick
          if (rx_cnt == BIT_SAMPLE) rx_ferr_n = ~rx_s;
          if (rx_cnt == stop_last(rx_stop)) begin
            rx_push    = 1'b1;
            rx_state_n = ST_IDLE;
          end else begin
            rx_cnt_n = rx_cnt + 5'd1;
          end
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
    rx_wdata = {rx_ferr_n, rx_perr, rx_b};
  end

  sync_fifo_sr #(.W(DBIT+2), .AW(FIFO_W)) u_rx_fifo (
    .clk    (clk),
    .resetn (reset),
    .wr     (rx_push),
    .rd     (rd_uart),
    .w_data (rx_wdata),
    .r_data (rx_head),
    .empty  (rx_empty),
    .full   (rx_full)
  );

  assign r_data = rx_head[DBIT-1:0];
  assign r_perr = rx_head[DBIT];
  assign r_ferr = rx_head[DBIT+1];

  // a push into a full FIFO survives only when a read frees a slot that cycle
  always_ff @(posedge clk) begin
    if (!reset)                              overrun <= 1'b0;
    else if (rx_push && rx_full && !rd_uart) overrun <= 1'b1;
    else if (clr_ovr)                        overrun <= 1'b0;
  end

  uart_state_t     tx_state, tx_state_n;
  logic [4:0]      tx_cnt, tx_cnt_n;
  logic [NW-1:0]   tx_n, tx_n_n;
  logic [DBIT-1:0] tx_b, tx_b_n, tx_head;
  logic            tx_pbit, tx_pbit_n, tx_pen, tx_pen_n;
  logic [1:0]      tx_stop, tx_stop_n;
  logic            tx_reg, tx_reg_n;
  logic            tx_pop, tx_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      tx_pbit  <= 1'b0;
      tx_pen   <= 1'b0;
      tx_stop  <= STOP_1;
      tx_reg   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_n     <= tx_n_n;
      tx_b     <= tx_b_n;
      tx_pbit  <= tx_pbit_n;
      tx_pen   <= tx_pen_n;
      tx_stop  <= tx_stop_n;
      tx_reg   <= tx_reg_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_n_n     = tx_n;
    tx_b_n     = tx_b;
    tx_pbit_n  = tx_pbit;
    tx_pen_n   = tx_pen;
    tx_stop_n  = tx_stop;
    tx_reg_n   = tx_reg;
    tx_pop     = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        tx_reg_n = 1'b1;
        if (!tx_empty) begin
          tx_state_n = ST_START;
          tx_cnt_n   = '0;
          tx_b_n     = tx_head;
          tx_pbit_n  = par_bit(par_sel, ^tx_head);
          tx_pen_n   = par_en(par_sel);
          tx_stop_n  = stop_sel;
          tx_reg_n   = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tx_cnt == BIT_SAMPLE) begin
            tx_cnt_n   = '0;
            tx_n_n     = '0;
            tx_state_n = ST_DATA;
            tx_reg_n   = tx_b[0];
          end else begin
            tx_cnt_n = tx_cnt + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tx_cnt == BIT_SAMPLE) begin
            tx_cnt_n = '0;
            tx_b_n   = tx_b >> 1;
            if (tx_n == NW'(DBIT-1)) begin
              tx_state_n = tx_pen ? ST_PAR : ST_STOP;
              tx_reg_n   = tx_pen ? tx_pbit : 1'b1;
            end else begin
              tx_n_n   = tx_n + 1'b1;
              tx_reg_n = tx_b[1];
            end
          end else begin
            tx_cnt_n = tx_cnt + 5'd1;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          if (tx_cnt == BIT_SAMPLE) begin
            tx_cnt_n   = '0;
            tx_state_n = ST_STOP;
            tx_reg_n   = 1'b1;
          end else begin
            tx_cnt_n = tx_cnt + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tx_cnt == stop_last(tx_stop)) begin
            tx_pop     = 1'b1;
            tx_state_n = ST_IDLE;
          end else begin
            tx_cnt_n = tx_cnt + 5'd1;
          end
        end
      end
      default: tx_state_n = ST_IDLE;
    endcase
  end

  sync_fifo_sr #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk    (clk),
    .resetn (reset),
    .wr     (wr_uart),
    .rd     (tx_pop),
    .w_data (w_data),
    .r_data (tx_head),
    .empty  (tx_empty),
    .full   (tx_full)
  );

  assign tx      = tx_reg;
  assign tx_idle = (tx_state == ST_IDLE) && tx_empty;

endmodule

// File: tb/tb_uart_cfg.sv
// tb/tb_uart_cfg.sv - randomized self-checking bench for uart_cfg against a frame-level model
module tb_uart_cfg;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic [1:0]  par_sel, stop_sel;
  logic        rx, rx_drv, loop_en;
  logic        rd_uart, wr_uart, clr_ovr;
  logic [7:0]  w_data, r_data;
  logic        r_perr, r_ferr, rx_empty, tx_full, tx_idle, overrun, tx;

  int n_checks = 0;
  int n_fail   = 0;
  int dv;
  logic [9:0] rxq[$];
  logic model_ovr = 1'b0;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_cfg #(.DBIT(8), .DVSR_BIT(11), .FIFO_W(2)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .par_sel(par_sel), .stop_sel(stop_sel),
    .rx(rx), .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data), .clr_ovr(clr_ovr),
    .r_data(r_data), .r_perr(r_perr), .r_ferr(r_ferr), .rx_empty(rx_empty),
    .tx_full(tx_full), .tx_idle(tx_idle), .overrun(overrun), .tx(tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic par_on(input logic [1:0] ps);
    return (ps == 2'd1) || (ps == 2'd2);
  endfunction

  // parity bit that makes the total count of ones even (ps=1) or odd (ps=2)
  function automatic logic exp_par(input logic [1:0] ps, input logic [7:0] d);
    logic ones_odd;
    ones_odd = ($countones(d) % 2) == 1;
    return (ps == 2'd2) ? !ones_odd : ones_odd;
  endfunction

  function automatic void model_push(input logic [9:0] e);
    if (rxq.size() < 4) rxq.push_back(e);
    else                model_ovr = 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dv(input int v);
    dv   = v;
    dvsr = 11'(v);
  endtask

  task automatic write_tx(input logic [7:0] d);
    wr_uart = 1'b1;
    w_data  = d;
    cyc(1);
    wr_uart = 1'b0;
  endtask

  task automatic wait_tx_fall(output int n);
    n = 0;
    while (tx !== 1'b0 && n < 20000) begin
      cyc(1);
      n++;
    end
    if (n >= 20000) check("tx_fall_timeout", 1, 0);
  endtask

  task automatic wait_tx_idle(output int n);
    n = 0;
    while (tx_idle !== 1'b1 && n < 20000) begin
      cyc(1);
      n++;
    end
    if (n >= 20000) check("tx_idle_timeout", 1, 0);
  endtask

  task automatic expect_rx(input string tag);
    int n;
    logic [9:0] e;
    n = 0;
    while (rx_empty !== 1'b0 && n < 20000) begin
      cyc(1);
      n++;
    end
    if (n >= 20000) begin
      check({tag, "_timeout"}, 1, 0);
    end else if (rxq.size() == 0) begin
      check({tag, "_unexpected"}, 1, 0);
    end else begin
      e = rxq.pop_front();
      check({tag, "_data"}, 32'(r_data), 32'(e[7:0]));
      check({tag, "_perr"}, 32'(r_perr), 32'(e[8]));
      check({tag, "_ferr"}, 32'(r_ferr), 32'(e[9]));
      rd_uart = 1'b1;
      cyc(1);
      rd_uart = 1'b0;
    end
  endtask

  // bit-level serial source on rx_drv; a bad stop bit is low for 12 of its 16 ticks
  task automatic drive_rx(input logic [7:0] d, input logic [1:0] ps, input logic flip,
                          input logic bad_stop);
    int bp;
    bp = 16 * (dv + 1);
    rx_drv = 1'b0;
    cyc(bp);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      cyc(bp);
    end
    if (par_on(ps)) begin
      rx_drv = exp_par(ps, d) ^ flip;
      cyc(bp);
    end
    if (bad_stop) begin
      rx_drv = 1'b0;
      cyc(12 * (dv + 1));
    end
    rx_drv = 1'b1;
    cyc(3 * bp);
  endtask

  initial begin
    int d1, d2;
    logic [7:0] b;
    logic [1:0] ps;
    logic flip;

    reset = 1'b0; rd_uart = 1'b0; wr_uart = 1'b0; clr_ovr = 1'b0; w_data = '0;
    rx_drv = 1'b1; loop_en = 1'b0; par_sel = 2'd0; stop_sel = 2'd0;
    set_dv(26);
    cyc(3);
    check("rst_tx", 32'(tx), 1);
    check("rst_tx_idle", 32'(tx_idle), 1);
    check("rst_rx_empty", 32'(rx_empty), 1);
    check("rst_tx_full", 32'(tx_full), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_r_data", 32'(r_data), 0);
    check("rst_r_perr", 32'(r_perr), 0);
    check("rst_r_ferr", 32'(r_ferr), 0);
    reset = 1'b1;
    cyc(2);

    // loopback at dvsr=26, 8N1
    loop_en = 1'b1;
    write_tx(8'hA5);
    model_push({2'b00, 8'hA5});
    check("wr_lat_1clk", 32'(tx), 1);
    cyc(1);
    check("wr_lat_2clk", 32'(tx), 0);
    wait_tx_idle(d1);
    check("frame_len_8n1", 32'(d1 >= 159*27 + 1 && d1 <= 160*27), 1);
    expect_rx("lb_a5");
    write_tx(8'h3C);
    model_push({2'b00, 8'h3C});
    expect_rx("lb_3c");
    wait_tx_idle(d1);

    // even parity on the wire, then a bad parity bit on rx
    set_dv(3);
    par_sel = 2'd1;
    write_tx(8'h07);
    model_push({2'b00, 8'h07});
    wait_tx_fall(d1);
    cyc(9*64 + 32);
    check("even_par_bit", 32'(tx), 32'(exp_par(2'd1, 8'h07)));
    expect_rx("ev_lb");
    wait_tx_idle(d1);
    loop_en = 1'b0;
    drive_rx(8'h07, 2'd1, 1'b1, 1'b0);
    model_push({2'b01, 8'h07});
    expect_rx("ev_perr");

    // random configs through the loopback path
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      par_sel  = 2'($urandom_range(0, 3));
      stop_sel = 2'($urandom_range(0, 3));
      b = 8'($urandom);
      write_tx(b);
      model_push({2'b00, b});
      expect_rx("rnd_lb");
      wait_tx_idle(d1);
    end

    // random driven frames with random parity corruption
    loop_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ps = 2'($urandom_range(0, 3));
      par_sel  = ps;
      stop_sel = 2'($urandom_range(0, 3));
      b = 8'($urandom);
      flip = par_on(ps) ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_rx(b, ps, flip, 1'b0);
      model_push({1'b0, flip, b});
      expect_rx("rnd_drv");
    end

    // framing error, then a clean frame to show resynchronisation
    par_sel = 2'd0; stop_sel = 2'd0;
    drive_rx(8'h55, 2'd0, 1'b0, 1'b1);
    model_push({2'b10, 8'h55});
    expect_rx("ferr");
    b = 8'($urandom);
    drive_rx(b, 2'd0, 1'b0, 1'b0);
    model_push({2'b00, b});
    expect_rx("resync");

    // overrun: five frames, no reads
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      drive_rx(b, 2'd0, 1'b0, 1'b0);
      model_push({2'b00, b});
    end
    check("ovr_set", 32'(overrun), 32'(model_ovr));
    for (int i = 0; i < 4; i++) expect_rx("ovr_pop");
    check("ovr_drained", 32'(rx_empty), 32'(rxq.size() == 0));
    clr_ovr = 1'b1;
    cyc(1);
    clr_ovr = 1'b0;
    model_ovr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'(model_ovr));

    // glitch: 4 ticks low
    rx_drv = 1'b0;
    cyc(4 * (dv + 1));
    rx_drv = 1'b1;
    cyc(40 * (dv + 1));
    check("glitch_reject", 32'(rx_empty), 32'(rxq.size() == 0));

    // odd parity, two stop bits, then reset mid-frame
    loop_en = 1'b1;
    par_sel = 2'd2; stop_sel = 2'd2;
    write_tx(8'h00);
    model_push({2'b00, 8'h00});
    wait_tx_fall(d1);
    cyc(9*64 + 32);
    check("odd_par_bit", 32'(tx), 32'(exp_par(2'd2, 8'h00)));
    wait_tx_idle(d2);
    d2 = d2 + 9*64 + 32;
    check("frame_len_8o2", 32'(d2 >= 191*4 + 1 && d2 <= 192*4), 1);
    check("peek_empty", 32'(rx_empty), 32'(rxq.size() == 0));
    check("peek_data", 32'(r_data), 32'(rxq.size() > 0 ? rxq[0][7:0] : 8'h00));
    write_tx(8'($urandom));
    cyc(300);
    reset = 1'b0;
    cyc(1);
    check("midrst_tx", 32'(tx), 1);
    check("midrst_tx_idle", 32'(tx_idle), 1);
    check("midrst_rx_empty", 32'(rx_empty), 1);
    reset = 1'b1;
    rxq.delete();
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cfg.md
# uart_cfg

Runtime-configurable UART with 16× oversampling, programmable baud divisor, optional even/odd parity, 1/1.5/2 stop bits, per-byte error flags and a sticky overrun flag. It is the next generation of the fixed-format UART top. It sits between a host-side register/bus interface (`rd_uart`/`wr_uart` strobes) and the `rx`/`tx` pins. Both directions are buffered by show-ahead FIFOs.

## Interface
- `DBIT`, 8: data bits per frame, legal range 5–8.
- `DVSR_BIT`, 11: width of the runtime divisor port.
- `FIFO_W`, 2: address bits per FIFO; depth is 2^FIFO_W.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `dvsr`  in  DVSR_BIT  baud divisor; tick period is dvsr+1 clocks; dvsr = f_clk/(16·baud) − 1.
- `par_sel`  in  2  0 = none, 1 = even, 2 = odd, 3 = none.
- `stop_sel`  in  2  0 = 1 stop bit, 1 = 1.5 stop bits, 2 or 3 = 2 stop bits.
- `rx`  in  1  serial input, asynchronous.
- `rd_uart`  in  1  pop RX FIFO head.
- `wr_uart`  in  1  push `w_data` into TX FIFO.
- `w_data`  in  DBIT  transmit byte.
- `clr_ovr`  in  1  clear `overrun`.
- `r_data`  out  DBIT  RX FIFO head data.
- `r_perr`  out  1  parity error flag of the head entry.
- `r_ferr`  out  1  framing error flag of the head entry.
- `rx_empty`  out  1  RX FIFO empty.
- `tx_full`  out  1  TX FIFO full.
- `tx_idle`  out  1  TX FSM idle and TX FIFO empty.
- `overrun`  out  1  sticky flag: a received byte was dropped.
- `tx`  out  1  serial output.

## Operation
- **Baud generator:** free-running counter. `tick` is asserted for one clock when count ≥ `dvsr`, and the counter then returns to 0. A `dvsr` change takes effect without a restart. `dvsr = 0` gives a tick every clock.
- **RX synchroniser:** 2-flop synchroniser on `rx`; both flops reset to 1.
- **RX FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE → START on a synchronised low level; `par_sel` and `stop_sel` are latched at this point.
  - START: at tick 7, if rx is still low, reset the tick count and go to DATA; otherwise return to IDLE (glitch reject).
  - DATA: sample each bit at tick 15, LSB first, DBIT bits.
  - PAR (entered only if parity is enabled): sample at tick 15 and compare against the even/odd parity of the data.
  - STOP: lasts 16, 24 or 32 ticks. The first stop bit is sampled at tick 15; a low level sets the framing error.
  - On STOP completion, push {ferr, perr, data} into the RX FIFO and return to IDLE.
- **Overrun:** if the RX FIFO is full at push, the byte is dropped and `overrun` is set. `clr_ovr` clears it. If set and clear coincide, set wins.
- **TX FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE → START when the TX FIFO is non-empty. The FIFO head and config are latched at this point; `tx` drives 0.
  - Each bit lasts 16 ticks. Data goes out LSB first, then the parity bit if enabled, then stop bits (`tx` = 1) for 16/24/32 ticks.
  - At the end of STOP, pop the TX FIFO and return to IDLE.
- **FIFOs:** show-ahead (head visible while not empty).
  - Write when full is ignored, except when a read occurs in the same cycle, in which case both happen.
  - Read when empty is ignored.
  - Simultaneous read and write when empty: the write happens, the read is ignored.

## Timing
- **Reset values:** `tx` = 1, `tx_idle` = 1, `rx_empty` = 1, `tx_full` = 0, `overrun` = 0; `r_data`, `r_perr`, `r_ferr` = 0. Both FSMs go to IDLE and both FIFOs are emptied.
- **Reset mid-frame:** the frame is aborted; `tx` is 1 in the first cycle after reset is sampled low.
- **`wr_uart` to `tx` falling edge:** 2 clocks when TX is idle (FIFO write, then FSM start).
- **Frame length:** (1 + DBIT + P + S) × 16 × (dvsr+1) clocks, where P = 1 if parity is enabled and S = 1, 1.5 or 2.
- **`rx_empty` deassertion:** in the clock after the STOP tick that completes the frame.
- **`rd_uart` to next head:** `r_data` shows the next entry in the following cycle.
- **Config changes:** affect only frames that start afterwards.

## Structure
- **Package `uart_cfg_pkg`:** parity and stop-select encodings, the FSM state enumeration, and oversample constants (16; start sample point 7; bit sample point 15).
- **Sub-module:** `sync_fifo_sr`, a parametrised width/depth show-ahead FIFO with synchronous active-low reset. It is instantiated twice: RX width DBIT+2, TX width DBIT.
- **Top-level logic:** baud generator and both FSMs live in `uart_cfg`.

## Test plan
- **Loopback:** tx→rx, dvsr = 26, par none, 1 stop; write 0xA5, 0x3C → RX FIFO holds 0xA5 then 0x3C, no error flags; each frame is 10 × 16 × 27 = 4320 clocks.
- **Even parity:** write 0x07 → parity bit 1 on `tx`. Drive `rx` with 0x07 and parity bit 0 → `r_data` = 0x07, `r_perr` = 1.
- **Framing error:** drive `rx` with 0x55 and a low stop bit → `r_ferr` = 1, `r_data` = 0x55. Then feed a normal frame and confirm the receiver resynchronises.
- **Overrun:** FIFO_W = 2; send 5 frames with no reads → 4 entries stored, 5th dropped, `overrun` = 1. Pulse `clr_ovr` → `overrun` = 0.
- **Glitch reject:** `rx` low for 4 ticks → no push, `rx_empty` stays 1.
- **Reset and 2-stop/odd parity:** stop_sel = 2, odd parity, write 0x00 → parity bit 1 and 32 stop ticks. Assert reset mid-frame → `tx` = 1 next cycle, `tx_idle` = 1, `rx_empty` = 1.
